// File: rtl/gearbox_132_128.sv
// rtl/gearbox_132_128.sv - TX gearbox packing 132-bit link blocks into 128-bit PHY beats (33 beats per 32 blocks)
// Residue is kept MSB-aligned in hold_q; fill_q counts valid 4-bit units (0..32).
module gearbox_132_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [131:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  logic [5:0]   fill_q, fill_d;
  logic [127:0] hold_q, hold_d;
  logic [127:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;

  logic         advance;
  logic         full;
  logic [8:0]   shamt;
  logic [259:0] cat;

  assign advance = !dout_valid_q || dout_ready;
  assign full    = (fill_q == 6'd32);

  // Gated by rst_n so the source sees no acceptance while the block is held in reset.
  assign din_ready = rst_n && advance && !full;

  // Place din directly below the 4*fill valid residue bits inside a 260-bit window.
  assign shamt = 9'd128 - {1'b0, fill_q, 2'b00};
  assign cat   = {hold_q, 132'd0} | ({128'd0, din} << shamt);

  always_comb begin
    fill_d       = fill_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (advance) begin
      if (full) begin
        dout_d       = hold_q;
        dout_valid_d = 1'b1;
        hold_d       = 128'd0;
        fill_d       = 6'd0;
      end else if (din_valid) begin
        dout_d       = cat[259:132];
        hold_d       = cat[131:4];
        fill_d       = fill_q + 6'd1;
        dout_valid_d = 1'b1;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q       <= 6'd0;
      hold_q       <= 128'd0;
      dout_q       <= 128'd0;
      dout_valid_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
